// File: rtl/huffman_pkg.sv
// Shared constants, state encoding and table field helper
// for the serial Huffman decoder.
package huffman_pkg;

  localparam int MAX_LEN = 3;
  localparam int NSYM    = 4;
  localparam int SYM_W   = 4;
  localparam int BUS_W   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    EMIT  = 2'd2
  } state_t;

  function automatic logic [BUS_W-1:0] get_field(
    input logic [BUS_W-1:0] bus,
    input int               i,
    input int               w
  );
    logic [BUS_W-1:0] mask;
    mask = (BUS_W'(1) << w) - BUS_W'(1);
    return (bus >> (i * w)) & mask;
  endfunction

endpackage

// File: rtl/huffman_code_match.sv
// Combinational prefix-code lookup: finds the lowest table slot
// whose length and code match the bits gathered so far.
module huffman_code_match #(
  parameter int MAX_LEN = 3,
  parameter int SYM_W   = 4
) (
  input  logic [MAX_LEN-1:0]   acc_i,
  input  logic [1:0]           cnt_i,
  input  logic [4*MAX_LEN-1:0] code_i,
  input  logic [7:0]           len_i,
  input  logic [4*SYM_W-1:0]   label_i,
  output logic                 hit_o,
  output logic [1:0]           idx_o,
  output logic [SYM_W-1:0]     label_o
);
  import huffman_pkg::*;

  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] code;
  logic [1:0]         len;

  always_comb begin
    hit_o   = 1'b0;
    idx_o   = '0;
    label_o = '0;
    code    = '0;
    len     = '0;
    mask    = MAX_LEN'((32'd1 << cnt_i) - 32'd1);
    for (int i = 0; i < NSYM; i++) begin
      code = MAX_LEN'(get_field(BUS_W'(code_i), i, MAX_LEN));
      len  = 2'(get_field(BUS_W'(len_i), i, 2));
      // Unused slots have len 0 and never match since cnt_i >= 1.
      if (!hit_o && len == cnt_i &&
          (code & mask) == (acc_i & mask)) begin
        hit_o   = 1'b1;
        idx_o   = 2'(i);
        label_o = SYM_W'(get_field(BUS_W'(label_i), i, SYM_W));
      end
    end
  end

endmodule

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: one coded bit per cycle in, one symbol
// label per valid/ready handshake out, with a loadable 4-slot table.
module huffman_decoder #(
  parameter int MAX_LEN = 3,
  parameter int SYM_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 tbl_load,
  input  logic [4*MAX_LEN-1:0] tbl_code,
  input  logic [7:0]           tbl_len,
  input  logic [4*SYM_W-1:0]   tbl_label,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 bit_ready,
  output logic [SYM_W-1:0]     sym_out,
  output logic [1:0]           sym_idx,
  output logic                 sym_valid,
  input  logic                 sym_ready,
  output logic                 code_err,
  output logic [CNT_W-1:0]     sym_count
);
  import huffman_pkg::*;

  state_t               state_q;
  logic [MAX_LEN-1:0]   acc_q;
  logic [1:0]           cnt_q;
  logic [4*MAX_LEN-1:0] code_q;
  logic [7:0]           len_q;
  logic [4*SYM_W-1:0]   label_q;
  logic                 sym_valid_q;
  logic [SYM_W-1:0]     sym_out_q;
  logic [1:0]           sym_idx_q;
  logic                 code_err_q;
  logic [CNT_W-1:0]     sym_count_q;

  logic [MAX_LEN-1:0]   acc_d;
  logic [1:0]           cnt_d;
  logic                 hit;
  logic [1:0]           hit_idx;
  logic [SYM_W-1:0]     hit_label;

  assign acc_d = {acc_q[MAX_LEN-2:0], bit_in};
  assign cnt_d = cnt_q + 2'd1;

  // A table load in the same cycle always wins over an offered bit.
  assign bit_ready = (state_q == SHIFT) && !tbl_load;

  huffman_code_match #(
    .MAX_LEN (MAX_LEN),
    .SYM_W   (SYM_W)
  ) u_match (
    .acc_i   (acc_d),
    .cnt_i   (cnt_d),
    .code_i  (code_q),
    .len_i   (len_q),
    .label_i (label_q),
    .hit_o   (hit),
    .idx_o   (hit_idx),
    .label_o (hit_label)
  );

  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      code_q      <= '0;
      len_q       <= '0;
      label_q     <= '0;
      sym_valid_q <= 1'b0;
      sym_out_q   <= '0;
      sym_idx_q   <= '0;
      code_err_q  <= 1'b0;
      sym_count_q <= '0;
    end else begin
      code_err_q <= 1'b0;
      if (tbl_load) begin
        code_q      <= tbl_code;
        len_q       <= tbl_len;
        label_q     <= tbl_label;
        acc_q       <= '0;
        cnt_q       <= '0;
        sym_valid_q <= 1'b0;
        state_q     <= SHIFT;
      end else begin
        unique case (state_q)
          IDLE: ;
          SHIFT: begin
            if (bit_valid) begin
              if (hit) begin
                acc_q       <= acc_d;
                cnt_q       <= cnt_d;
                sym_valid_q <= 1'b1;
                sym_out_q   <= hit_label;
                sym_idx_q   <= hit_idx;
                state_q     <= EMIT;
              end else if (cnt_d == 2'(MAX_LEN)) begin
                acc_q      <= '0;
                cnt_q      <= '0;
                code_err_q <= 1'b1;
              end else begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
              end
            end
          end
          EMIT: begin
            if (sym_ready) begin
              acc_q       <= '0;
              cnt_q       <= '0;
              sym_valid_q <= 1'b0;
              sym_count_q <= sym_count_q + 1'b1;
              state_q     <= SHIFT;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sym_valid = sym_valid_q;
  assign sym_out   = sym_out_q;
  assign sym_idx   = sym_idx_q;
  assign code_err  = code_err_q;
  assign sym_count = sym_count_q;

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed plus randomized bench for huffman_decoder against a
// bit-string prefix-match reference model.
module tb_huffman_decoder;

  localparam int CW = 4;

  logic        CLK = 1'b0;
  logic        nRST = 1'b1;
  logic        tbl_load = 1'b0;
  logic [11:0] tbl_code = '0;
  logic [7:0]  tbl_len = '0;
  logic [15:0] tbl_label = '0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        sym_ready = 1'b1;
  logic        bit_ready;
  logic [3:0]  sym_out;
  logic [1:0]  sym_idx;
  logic        sym_valid;
  logic        code_err;
  logic [CW-1:0] sym_count;

  int nvec = 0;
  int nerr = 0;

  int m_code[4];
  int m_len[4];
  int m_lab[4];
  int m_bits, m_n, m_cnt, m_last_lab;
  bit pending;

  huffman_decoder #(
    .MAX_LEN (3),
    .SYM_W   (4),
    .CNT_W   (CW)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .tbl_load  (tbl_load),
    .tbl_code  (tbl_code),
    .tbl_len   (tbl_len),
    .tbl_label (tbl_label),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .sym_out   (sym_out),
    .sym_idx   (sym_idx),
    .sym_valid (sym_valid),
    .sym_ready (sym_ready),
    .code_err  (code_err),
    .sym_count (sym_count)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear_table();
    for (int i = 0; i < 4; i++) begin
      m_code[i] = 0;
      m_len[i]  = 0;
      m_lab[i]  = 0;
    end
    m_bits  = 0;
    m_n     = 0;
    pending = 1'b0;
  endtask

  task automatic drain();
    sym_ready = 1'b1;
    tick();
    m_cnt++;
    pending = 1'b0;
    check("drain_valid", sym_valid, 0);
    check("sym_count", sym_count, m_cnt % (1 << CW));
  endtask

  task automatic stall(input int n);
    sym_ready = 1'b0;
    bit_in    = 1'b1;
    bit_valid = 1'b1;
    repeat (n) begin
      tick();
      check("stall_valid", sym_valid, 1);
      check("stall_out", sym_out, m_last_lab);
      check("stall_ready", bit_ready, 0);
    end
    bit_valid = 1'b0;
  endtask

  task automatic send_bit(input int b);
    int hit_i;
    bit err;
    check("bit_ready_pre", bit_ready, 1);
    bit_in    = b[0];
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    m_bits = m_bits * 2 + b;
    m_n++;
    hit_i = -1;
    for (int i = 0; i < 4; i++)
      if (hit_i < 0 && m_len[i] == m_n &&
          (m_bits % (1 << m_n)) == (m_code[i] % (1 << m_n)))
        hit_i = i;
    err = (hit_i < 0) && (m_n == 3);
    if (hit_i >= 0) begin
      check("sym_valid", sym_valid, 1);
      check("sym_out", sym_out, m_lab[hit_i]);
      check("sym_idx", sym_idx, hit_i);
      check("emit_ready", bit_ready, 0);
      check("code_err_hit", code_err, 0);
      m_last_lab = m_lab[hit_i];
      pending = 1'b1;
      m_bits = 0;
      m_n = 0;
    end else begin
      check("no_valid", sym_valid, 0);
      check("code_err", code_err, err);
      if (err) begin
        m_bits = 0;
        m_n = 0;
      end
    end
    if (pending && sym_ready) drain();
  endtask

  task automatic load(input logic [11:0] c, input logic [7:0] l,
                      input logic [15:0] lab, input bit with_bit);
    tbl_code  = c;
    tbl_len   = l;
    tbl_label = lab;
    tbl_load  = 1'b1;
    bit_in    = 1'b1;
    bit_valid = with_bit;
    #1;
    check("load_ready", bit_ready, 0);
    tick();
    tbl_load  = 1'b0;
    bit_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_code[i] = (int'(c) >> (3 * i)) & 7;
      m_len[i]  = (int'(l) >> (2 * i)) & 3;
      m_lab[i]  = (int'(lab) >> (4 * i)) & 15;
    end
    m_bits  = 0;
    m_n     = 0;
    pending = 1'b0;
    #1;
    check("load_valid", sym_valid, 0);
    check("post_load_ready", bit_ready, 1);
  endtask

  task automatic reset_seq();
    nRST = 1'b1;
    tick();
    check("rst_ready", bit_ready, 0);
    check("rst_valid", sym_valid, 0);
    check("rst_out", sym_out, 0);
    check("rst_idx", sym_idx, 0);
    check("rst_err", code_err, 0);
    check("rst_count", sym_count, 0);
    nRST = 1'b0;
    tick();
    check("idle_ready", bit_ready, 0);
    check("idle_valid", sym_valid, 0);
    m_cnt = 0;
    model_clear_table();
  endtask

  localparam logic [11:0] CODE_A = {3'b111, 3'b110, 3'b010, 3'b000};
  localparam logic [7:0]  LEN_A  = {2'd3, 2'd3, 2'd2, 2'd1};
  localparam logic [7:0]  LEN_E  = {2'd0, 2'd0, 2'd2, 2'd1};
  localparam logic [15:0] LAB_A  = 16'hDCBA;

  initial begin
    m_cnt = 0;
    model_clear_table();

    tick();
    reset_seq();

    sym_ready = 1'b1;
    load(CODE_A, LEN_A, LAB_A, 1'b0);

    send_bit(0);
    sym_ready = 1'b0;
    send_bit(1);
    send_bit(0);
    stall(5);
    drain();
    send_bit(1); send_bit(1); send_bit(0);
    send_bit(1); send_bit(1); send_bit(1);
    check("count_four", sym_count, 4);

    load(CODE_A, LEN_E, LAB_A, 1'b0);
    send_bit(1); send_bit(1); send_bit(1);
    tick();
    check("err_one_cycle", code_err, 0);
    check("err_no_valid", sym_valid, 0);
    send_bit(0);

    load(CODE_A, LEN_A, LAB_A, 1'b0);
    send_bit(1); send_bit(1);
    load(CODE_A, LEN_A, LAB_A, 1'b1);
    send_bit(0);

    sym_ready = 1'b0;
    send_bit(1);
    send_bit(0);
    reset_seq();

    sym_ready = 1'b1;
    load(CODE_A, LEN_A, LAB_A, 1'b0);
    repeat (16) send_bit(0);
    check("count_wrap", sym_count, 0);

    for (int r = 0; r < 6; r++) begin
      load(12'($urandom), 8'($urandom), 16'($urandom),
           1'($urandom_range(0, 1)));
      for (int k = 0; k < 60; k++) begin
        sym_ready = 1'($urandom_range(0, 1));
        send_bit(int'($urandom_range(0, 1)));
        if (pending) begin
          stall(int'($urandom_range(1, 3)));
          drain();
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/huffman_decoder.md
Name: huffman_decoder

Overview:
- Decodes a serial Huffman bitstream back into 4-bit symbol labels.
- Uses a 4-symbol prefix-code table that is loaded in parallel.
- It is the consumer-side counterpart of the tree generator and encoder path: tree-derived codes go into the table, and coded bits arrive one per cycle.
- Each decoded symbol is presented on a valid/ready output port.

Parameters:
- MAX_LEN, 3: maximum code length in bits. A 4-leaf tree never exceeds 3.
- SYM_W, 4: width of one symbol label.
- CNT_W, 16: width of the decoded-symbol counter.

Ports:
- CLK  in  1  clock; all logic is rising-edge.
- nRST  in  1  synchronous, active-high reset (asserted = 1, despite the name).
- tbl_load  in  1  one-cycle pulse; captures the tbl_* buses.
- tbl_code  in  4*MAX_LEN  code for symbol i in bits [3i+2:3i], right-aligned, first-transmitted bit is the MSB of the used length.
- tbl_len  in  8  length of symbol i in bits [2i+1:2i]; 0 means the slot is unused.
- tbl_label  in  4*SYM_W  label of symbol i in bits [4i+3:4i].
- bit_in  in  1  coded bit.
- bit_valid  in  1  bit_in is valid.
- bit_ready  out  1  decoder accepts a bit this cycle.
- sym_out  out  SYM_W  decoded label.
- sym_idx  out  2  decoded table slot.
- sym_valid  out  1  sym_out and sym_idx are valid.
- sym_ready  in  1  downstream accepts the symbol.
- code_err  out  1  one-cycle pulse: MAX_LEN bits were received with no match.
- sym_count  out  CNT_W  number of symbols accepted downstream; wraps.

Behaviour:
- Reset (nRST=1 at a clock edge):
  - state=IDLE; acc=0, cnt=0.
  - Table registers cleared.
  - bit_ready=0, sym_valid=0, sym_out=0, sym_idx=0, code_err=0, sym_count=0.
  - Reset overrides everything, including during mid-symbol accumulation or EMIT.
- FSM states: IDLE, SHIFT, EMIT.
- IDLE:
  - bit_ready=0; no table is loaded.
  - tbl_load -> SHIFT.
- tbl_load in any state:
  - Registers all three table buses.
  - Clears acc and cnt, sets sym_valid=0, goes to SHIFT.
  - Any pending symbol is discarded and sym_count is not incremented.
  - Any bit offered in the same cycle is not accepted, because bit_ready is forced to 0 when tbl_load=1.
- SHIFT:
  - bit_ready=1 (combinational, from state and !tbl_load).
  - A transfer occurs when bit_valid && bit_ready. Then acc_n={acc[1:0],bit_in} and cnt_n=cnt+1.
  - Symbol i matches when tbl_len[i]==cnt_n and the low cnt_n bits of acc_n equal the low cnt_n bits of code i.
  - If any slot matches, the lowest index wins. Next cycle: sym_valid=1, sym_out=label, sym_idx=i, state=EMIT.
  - Latency is 1 cycle from the last accepted bit to sym_valid.
  - If there is no match and cnt_n==MAX_LEN: code_err=1 for exactly the next cycle, acc and cnt cleared, stay in SHIFT.
  - If there is no match and cnt_n<MAX_LEN: keep acc_n and cnt_n, stay in SHIFT.
  - No transfer: hold all state.
- EMIT:
  - bit_ready=0; sym_valid=1, and sym_out and sym_idx are held stable until accepted.
  - On sym_ready: sym_valid=0 next cycle, acc and cnt cleared, sym_count+1 (wraps 2^CNT_W-1 -> 0), state -> SHIFT.
  - sym_ready while sym_valid=0 has no effect.
- Throughput: one bit per cycle in SHIFT, plus at least 1 cycle in EMIT per symbol.
- The table is not checked for prefix-freedom. Ambiguity is resolved by the lowest-index rule.
- An all-zero table (every tbl_len=0) produces code_err every 3 accepted bits.

Decomposition:
- Package huffman_pkg holds:
  - MAX_LEN, NSYM=4, SYM_W.
  - State encoding: IDLE=2'd0, SHIFT=2'd1, EMIT=2'd2.
  - A function that extracts field i from the packed tbl_* buses.
- One sub-module, huffman_code_match:
  - Purely combinational.
  - Inputs: acc_n, cnt_n, and the registered table.
  - Outputs: hit, idx[1:0], label.
  - The top level holds the FSM, registers, and counter.

Test Plan:
- Reset and load: reset, then load table A=0/len1/label 4'hA, B=10/len2/4'hB, C=110/len3/4'hC, D=111/len3/4'hD, with sym_ready=1. Required: bit_ready=0 before the load and 1 the cycle after.
- Stream decode: bits 0,1,0,1,1,0,1,1,1 -> sym_out A, B, C, D in order. Each sym_valid appears 1 cycle after its final bit. sym_count=4 at the end.
- Backpressure: hold sym_ready=0 for 5 cycles after the B match. Required: sym_valid and sym_out=4'hB stable, bit_ready=0, and no bits consumed during the stall.
- Error: table with C and D set to len 0; send 1,1,1 -> code_err high for 1 cycle, no sym_valid. The next bit 0 decodes A.
- Mid-operation events:
  - tbl_load after the bits 1,1 -> accumulator cleared; the following bit 0 decodes A.
  - nRST asserted in EMIT -> all outputs return to reset values and the next cycle is IDLE.
- Counter wrap: preload via 65535 accepted symbols, or use CNT_W=4 with 16 symbols -> sym_count wraps to 0.
